// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM state encoding
// and the operand-width legality check.
`ifndef SERIAL_ADD_PKG_SV
`define SERIAL_ADD_PKG_SV

`define SERIAL_ADD_WIDTH_OK(w) (((w) >= 2) && ((w) <= 64))

package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial unit.
module serial_add_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full adder cell stepped LSB first over WIDTH
// cycles, with valid/ready handshakes on operands and result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_zero,
  output logic             busy
);

  if (!`SERIAL_ADD_WIDTH_OK(WIDTH)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be in 2..64");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cout_q, ovf_q, zero_q;
  logic             fa_sum, fa_carry;
  logic             last_step;
  logic [WIDTH-1:0] sum_nxt;

  serial_add_ctrl_full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  assign last_step = (state == ST_RUN) && (cnt == LAST);
  assign sum_nxt   = {fa_sum, sum_sh[WIDTH-1:1]};

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block purely
  // combinational; a path that left state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (op_valid)  state_nxt = ST_RUN;
        ST_RUN:  if (last_step) state_nxt = ST_DONE;
        ST_DONE: if (res_ready) state_nxt = ST_IDLE;
        default:                state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_ready  = (state == ST_IDLE);
    res_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  // Datapath: subtraction is A + ~B + 1, the +1 entering as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (flush) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            a_sh  <= op_a;
            b_sh  <= op_sub ? ~op_b : op_b;
            carry <= op_sub;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_carry;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            // carry is still the carry into the MSB at this edge
            ovf_q  <= carry ^ fa_carry;
            cout_q <= fa_carry;
            zero_q <= (sum_nxt == '0);
            cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_sum  = sum_sh;
  assign res_cout = cout_q;
  assign res_ovf  = ovf_q;
  assign res_zero = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random bench for serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_cout, res_ovf, res_zero, busy;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
    .res_zero(res_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic with signed-overflow from operand signs.
  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t r;
    logic [W:0] wide;
    if (sub) wide = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     wide = {1'b0, a} + {1'b0, b};
    r.sum  = wide[W-1:0];
    r.cout = wide[W];
    if (sub) r.ovf = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
    else     r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!op_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_idle_wait"}, op_ready, 1);
  endtask

  // Issue one operation and check latency, result and the return to IDLE.
  // hold: cycles to keep res_ready low once res_valid is up.
  // keep_valid: leave op_valid high with fresh operands during RUN.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input int hold, input logic keep_valid);
    res_t exp = model(a, b, sub);
    logic [W-1:0] snap;
    wait_idle(tag);
    res_ready = (hold == 0);
    op_a = a; op_b = b; op_sub = sub; op_valid = 1'b1;
    tick();
    if (keep_valid) begin
      op_a = $urandom; op_b = $urandom; op_sub = ~sub;
    end else begin
      op_valid = 1'b0;
    end
    check({tag, "_busy"}, {op_ready, busy}, 2'b01);
    repeat (W - 1) tick();
    check({tag, "_early_valid"}, res_valid, 0);
    tick();
    op_valid = 1'b0;
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_sum"}, res_sum, exp.sum);
    check({tag, "_flags"}, {res_cout, res_ovf, res_zero}, {exp.cout, exp.ovf, exp.zero});
    snap = res_sum;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_hold"}, {res_valid, op_ready, res_sum}, {1'b1, 1'b0, snap});
      end
      res_ready = 1'b1;
    end
    tick();
    check({tag, "_back_idle"}, {res_valid, op_ready, busy}, 3'b010);
  endtask

  initial begin
    // Reset held for three cycles, released away from the clock edge.
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", {op_ready, res_valid, busy}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ctrl", {op_ready, res_valid, busy}, 3'b100);
    check("rst_res", {res_sum, res_cout, res_ovf, res_zero}, '0);

    do_op("add",      32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
    do_op("sub_zero", 32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b0);
    do_op("borrow",   32'h0000_0000, 32'h0000_0001, 1'b1, 0, 1'b0);
    do_op("ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    do_op("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    do_op("ovf_sub",  32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0);
    do_op("backpr",   32'hDEAD_BEEF, 32'h1111_2222, 1'b0, 10, 1'b0);
    do_op("hold_vld", 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 0, 1'b1);

    // Flush in the tenth cycle of RUN.
    wait_idle("flush_run");
    res_ready = 1'b1;
    op_a = 32'h0000_1234; op_b = 32'h0000_4321; op_sub = 1'b0; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_run", {res_valid, op_ready, busy}, 3'b010);
    repeat (W + 2) tick();
    check("flush_no_result", res_valid, 0);

    // Flush together with an offered operand in IDLE.
    flush = 1'b1; op_valid = 1'b1;
    tick();
    flush = 1'b0; op_valid = 1'b0;
    check("flush_idle", {op_ready, busy}, 2'b10);
    tick();
    check("flush_idle_stay", {op_ready, busy, res_valid}, 3'b100);

    // Asynchronous reset between edges in the middle of RUN.
    op_a = 32'hFFFF_0000; op_b = 32'h0000_FFFF; op_sub = 1'b0; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    repeat (12) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {op_ready, res_valid, busy}, 3'b100);
    check("rst_mid_res", {res_sum, res_cout, res_ovf, res_zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b0);

    // Random operands against the model, with random result backpressure.
    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Multi-cycle bit-serial add/subtract unit. A controller sequences one shared 1-bit FullAdder cell over WIDTH cycles, LSB first.
- Used as an area-reduced arithmetic resource: address/offset calculation in low-power builds, and the iterative step engine for future M-extension units.
- Valid/ready handshake on both the operand side and the result side. Synchronous flush input for pipeline squash.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low. Assertion is asynchronous; deassertion is synchronised externally.
- flush  in  1  synchronous squash: abort the current operation and drop any held result.
- op_valid  in  1  operands presented.
- op_ready  out  1  unit can accept operands (high only in IDLE).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_sub  in  1  0 = A+B, 1 = A-B (computed as A + ~B + 1).
- res_valid  out  1  result held and valid.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  WIDTH  sum/difference.
- res_cout  out  1  carry out of the MSB (for subtract, 1 = no borrow).
- res_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- res_zero  out  1  res_sum == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (rst_n low): state=IDLE, op_ready=1, res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_zero=0, busy=0, counter=0, carry flop=0.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE: op_ready=1.
  - On op_valid & op_ready at edge T0:
    - latch op_a into shift register A;
    - latch (op_sub ? ~op_b : op_b) into shift register B;
    - carry flop <= op_sub;
    - counter <= 0;
    - go to RUN.
- RUN: each edge, the FullAdder takes A[0], B[0] and the carry flop.
  - The sum bit shifts into the MSB of the result register (shift right). A and B shift right.
  - Carry flop <= adder carry. Counter increments.
  - On the edge where counter == WIDTH-1:
    - capture carry-in to the MSB (the old carry flop) as the ovf term;
    - capture the final carry as cout;
    - go to DONE.
- Latency: operand handshake at edge T0 gives res_valid=1 after edge T0+WIDTH (32 cycles at default). op_ready=0 from T0+1 until the return to IDLE.
- DONE:
  - res_valid=1; res_sum/res_cout/res_ovf/res_zero stable until the handshake.
  - On res_valid & res_ready, go to IDLE at the next edge; op_ready=1 in the following cycle.
  - No same-cycle back-to-back: the minimum issue interval is WIDTH+2 cycles.
- Outputs are registered. res_zero is computed from the final result register, not accumulated per bit.
- op_ready is 0 in RUN and DONE. op_valid is ignored there and the operands are not sampled.
- flush=1 at any edge: next state IDLE, res_valid=0, counter=0; the result register contents are don't-care.
  - flush has priority over an op handshake and over a result handshake in the same cycle. An operand offered with flush=1 is not accepted.
- Reset mid-RUN or in DONE aborts immediately (asynchronous). No partial result is visible.
- Wrap: arithmetic is modulo 2^WIDTH. The carry beyond the MSB appears only in res_cout.
- res_ready held high before res_valid has no effect. res_valid must not drop without a handshake, flush or reset.

Decomposition:
- Shared package/header serial_add_pkg:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the WIDTH legality check macro.
- Sub-module: one instance of the existing FullAdder cell (A, B, cin -> sum, carry) as the only arithmetic element. No wide adder may be inferred.
- Control FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> op_ready=1, res_valid=0, busy=0, all result outputs 0.
- Add: A=0x0000_0005, B=0x0000_0003, sub=0, res_ready=1 -> res_valid rises exactly 32 cycles after accept; sum=0x0000_0008, cout=0, ovf=0, zero=0.
- Subtract/zero and borrow:
  - A=0x1234_5678 - B=0x1234_5678 -> sum=0, cout=1, zero=1, ovf=0.
  - A=0 - B=1 -> sum=0xFFFF_FFFF, cout=0, ovf=0.
- Overflow/wrap:
  - 0x7FFF_FFFF + 1 -> sum=0x8000_0000, ovf=1, cout=0.
  - 0xFFFF_FFFF + 1 -> sum=0, cout=1, zero=1, ovf=0.
  - 0x8000_0000 - 1 -> sum=0x7FFF_FFFF, ovf=1.
- Backpressure and handshake rules:
  - Hold res_ready=0 for 10 cycles after res_valid -> outputs stable and op_ready=0 throughout.
  - Raise res_ready -> IDLE one cycle later.
  - op_valid held high during RUN -> no second accept.
- Flush and reset:
  - Assert flush in cycle 10 of RUN -> IDLE next cycle, no res_valid.
  - Assert flush together with op_valid in IDLE -> not accepted.
  - Assert rst_n=0 mid-RUN (between edges) -> outputs reset immediately.
